// File: rtl/maxpool_engine_if.sv
// Stream interface of maxpool_engine: input beats from conv_block and the pooled/bypassed output beats.
// The master modport is the side that feeds beats in and accepts results.
interface maxpool_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_CORES = 8
);
    logic                             l_valid;
    logic                             l_rdy;
    logic [DATA_WIDTH*CONV_CORES-1:0] d_in;
    logic                             T_last_in;
    logic                             r_valid;
    logic                             r_rdy;
    logic [DATA_WIDTH*CONV_CORES-1:0] T_out;
    logic                             T_last_out;

    modport master (
        output l_valid, d_in, T_last_in, r_rdy,
        input  l_rdy, r_valid, T_out, T_last_out
    );

    modport slave (
        input  l_valid, d_in, T_last_in, r_rdy,
        output l_rdy, r_valid, T_out, T_last_out
    );
endinterface

// File: rtl/maxpool_engine.sv
// maxpool_engine: vertical lane-pair max followed by a 1..MAX_POOL_W beat horizontal max window, or bypass.
// Optional feature: define MAXPOOL_RELU_EN to clamp every output lane at zero on the output-register load.
module maxpool_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_CORES = 8,
    parameter int MAX_POOL_W = 4,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 mode,
    input  logic [CNT_WIDTH-1:0] pool_w,
    maxpool_engine_if.slave      s
);
    localparam int HALF = CONV_CORES / 2;
    localparam int LW   = DATA_WIDTH * CONV_CORES;

    typedef logic signed [DATA_WIDTH-1:0] elem_t;

    function automatic elem_t smax(input elem_t a, input elem_t b);
        return (a >= b) ? a : b;
    endfunction

    function automatic elem_t out_clamp(input elem_t a);
`ifdef MAXPOOL_RELU_EN
        return a[DATA_WIDTH-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    logic                 r_init;
    logic                 r_mode_win;
    logic [CNT_WIDTH-1:0] r_pw_win;
    logic [CNT_WIDTH-1:0] r_count;
    elem_t                r_acc [HALF];
    logic                 r_valid;
    logic                 r_tlast;
    logic [LW-1:0]        r_tout;

    logic                 w_first;
    logic                 w_mode;
    logic [CNT_WIDTH-1:0] w_pw_sat;
    logic [CNT_WIDTH-1:0] w_pw;
    logic                 w_close;
    logic                 w_ready;
    logic                 w_accept;
    elem_t                w_pooled [HALF];
    logic [LW-1:0]        w_load;

    // Window parameters come live from the ports on the first beat, then from the latched copy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_pw_sat = pool_w;
        if (int'(pool_w) > MAX_POOL_W - 1)
            w_pw_sat = CNT_WIDTH'(MAX_POOL_W - 1);
        w_first  = (r_count == '0);
        w_mode   = w_first ? mode : r_mode_win;
        w_pw     = w_first ? w_pw_sat : r_pw_win;
        w_close  = ~w_mode | s.T_last_in | (r_count == w_pw);
        // Only a beat that would load the output register has to wait for it.
        w_ready  = r_init & (~w_close | ~r_valid | s.r_rdy);
        w_accept = s.l_valid & w_ready;
    end

    always_comb begin
        elem_t w_hi;
        elem_t w_lo;
        elem_t w_v;
        for (int k = 0; k < HALF; k++) begin
            w_lo        = elem_t'(s.d_in[(2*k)*DATA_WIDTH +: DATA_WIDTH]);
            w_hi        = elem_t'(s.d_in[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]);
            w_v         = smax(w_lo, w_hi);
            w_pooled[k] = w_first ? w_v : smax(r_acc[k], w_v);
        end
    end

    always_comb begin
        w_load = '0;
        if (w_mode) begin
            for (int k = 0; k < HALF; k++)
                w_load[k*DATA_WIDTH +: DATA_WIDTH] = out_clamp(w_pooled[k]);
        end else begin
            for (int i = 0; i < CONV_CORES; i++)
                w_load[i*DATA_WIDTH +: DATA_WIDTH] = out_clamp(elem_t'(s.d_in[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_init     <= 1'b0;
            r_mode_win <= 1'b0;
            r_pw_win   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_tlast    <= 1'b0;
            r_tout     <= '0;
            // NOTE: the accumulator array is small register state, so it is reset; a partial window must not survive reset.
            for (int k = 0; k < HALF; k++)
                r_acc[k] <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                if (w_first) begin
                    r_mode_win <= mode;
                    r_pw_win   <= w_pw_sat;
                end
                if (w_mode) begin
                    for (int k = 0; k < HALF; k++)
                        r_acc[k] <= w_pooled[k];
                    r_count <= w_close ? '0 : r_count + CNT_WIDTH'(1);
                end
                if (w_close) begin
                    r_tout  <= w_load;
                    r_tlast <= s.T_last_in;
                end
            end
            if (w_accept && w_close)
                r_valid <= 1'b1;
            else if (s.r_rdy)
                r_valid <= 1'b0;
        end
    end

    assign s.l_rdy      = w_ready;
    assign s.r_valid    = r_valid;
    assign s.T_out      = r_tout;
    assign s.T_last_out = r_tlast;
endmodule

// File: tb/tb_maxpool_engine.sv
// Directed bench for maxpool_engine: bypass, pooling windows, partial flush, backpressure, reset, boundaries.
// Expected outputs follow the MAXPOOL_RELU_EN setting of the build.
module tb_maxpool_engine;
    localparam int DW = 16;
    localparam int CC = 8;
    localparam int LW = DW * CC;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] pool_w = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [LW-1:0] d;
        logic          last;
    } out_t;
    out_t q[$];

    maxpool_engine_if #(.DATA_WIDTH(DW), .CONV_CORES(CC)) itf ();

    maxpool_engine #(
        .DATA_WIDTH(DW), .CONV_CORES(CC), .MAX_POOL_W(4), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .pool_w(pool_w), .s(itf.slave)
    );

    always #5 clk = ~clk;

    // Record every completed output handshake.
    always @(negedge clk) begin
        if (rstn && itf.r_valid && itf.r_rdy)
            q.push_back('{d: itf.T_out, last: itf.T_last_out});
    end

    function automatic int rl(input int a);
`ifdef MAXPOOL_RELU_EN
        return (a < 0) ? 0 : a;
`else
        return a;
`endif
    endfunction

    function automatic logic [LW-1:0] mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [LW-1:0] mk8r(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return mk8(rl(a0), rl(a1), rl(a2), rl(a3), rl(a4), rl(a5), rl(a6), rl(a7));
    endfunction

    task automatic send_beat(input logic [LW-1:0] d, input logic last);
        int n = 0;
        itf.l_valid   = 1'b1;
        itf.d_in      = d;
        itf.T_last_in = last;
        forever begin
            @(negedge clk);
            if (itf.l_rdy) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_beat_timeout: l_rdy stayed %b, required 1", itf.l_rdy);
                break;
            end
        end
        @(posedge clk);
        #1;
        itf.l_valid   = 1'b0;
        itf.T_last_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [LW-1:0] exp_d, input logic exp_last);
        n_checks++;
        if (itf.r_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: got %b required 1", name, itf.r_valid);
        end
        n_checks++;
        if (itf.T_out !== exp_d) begin
            n_fail++;
            $display("FAIL %s_data: got %h required %h", name, itf.T_out, exp_d);
        end
        n_checks++;
        if (itf.T_last_out !== exp_last) begin
            n_fail++;
            $display("FAIL %s_last: got %b required %b", name, itf.T_last_out, exp_last);
        end
    endtask

    task automatic test_reset();
        itf.l_valid = 1'b0; itf.d_in = '0; itf.T_last_in = 1'b0; itf.r_rdy = 1'b1;
        rstn = 1'b0;
        idle(3);
        n_checks++;
        if (itf.r_valid !== 1'b0 || itf.T_out !== '0 || itf.T_last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b required all zero", itf.r_valid, itf.T_out, itf.T_last_out);
        end
        rstn = 1'b1;
        idle(1);
        n_checks++;
        if (itf.l_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_l_rdy: got %b required 1", itf.l_rdy);
        end
    endtask

    task automatic test_bypass();
        int v [5][8];
        q.delete();
        mode = 1'b0; itf.r_rdy = 1'b1;
        for (int b = 0; b < 5; b++)
            for (int i = 0; i < 8; i++)
                v[b][i] = (b + 1) * (i - 3) * 37;
        v[2][5] = -32768;
        for (int b = 0; b < 5; b++) begin
            send_beat(mk8(v[b][0], v[b][1], v[b][2], v[b][3], v[b][4], v[b][5], v[b][6], v[b][7]), b == 4);
            check_out($sformatf("bypass_b%0d", b),
                      mk8r(v[b][0], v[b][1], v[b][2], v[b][3], v[b][4], v[b][5], v[b][6], v[b][7]), b == 4);
        end
        idle(2);
        n_checks++;
        if (q.size() != 5 || itf.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_count: got %0d outputs v=%b required 5 v=0", q.size(), itf.r_valid);
        end
    endtask

    task automatic test_pool_basic();
        q.delete();
        mode = 1'b1; pool_w = 2'd1; itf.r_rdy = 1'b1;
        send_beat(mk8(3, 7, -8, -9, 10, 20, -30, -40), 1'b0);
        n_checks++;
        if (itf.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pool_basic_early: got r_valid=%b required 0", itf.r_valid);
        end
        send_beat(mk8(-2, 5, -1, -4, 15, 5, -50, -60), 1'b0);
        check_out("pool_basic", mk8r(7, -1, 20, -30, 0, 0, 0, 0), 1'b0);
        idle(2);
        n_checks++;
        if (q.size() != 1) begin
            n_fail++;
            $display("FAIL pool_basic_count: got %0d required 1", q.size());
        end
    endtask

    task automatic test_partial_flush();
        q.delete();
        mode = 1'b1; pool_w = 2'd3; itf.r_rdy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send_beat(mk8(i, -i, -i, -2 * i, 0, 0, 0, 0), i == 6);
            if (i == 4) check_out("flush_full", mk8r(4, -1, 0, 0, 0, 0, 0, 0), 1'b0);
            if (i == 6) check_out("flush_partial", mk8r(6, -5, 0, 0, 0, 0, 0, 0), 1'b1);
        end
        idle(2);
        n_checks++;
        if (q.size() != 2) begin
            n_fail++;
            $display("FAIL flush_count: got %0d required 2", q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] exp_w [3];
        int low_cnt = 0;
        exp_w[0] = mk8r(20, -1, 7, 7, 0, 0, 0, 0);
        exp_w[1] = mk8r(40, -3, 7, 7, 0, 0, 0, 0);
        exp_w[2] = mk8r(60, -5, 7, 7, 0, 0, 0, 0);
        q.delete();
        mode = 1'b1; pool_w = 2'd1; itf.r_rdy = 1'b1;
        send_beat(mk8(10, 0, -1, -100, 7, 7, 7, 7), 1'b0);
        send_beat(mk8(20, 0, -2, -100, 7, 7, 7, 7), 1'b0);
        itf.r_rdy = 1'b0;
        itf.l_valid = 1'b1; itf.d_in = mk8(30, 0, -3, -100, 7, 7, 7, 7);
        #1;
        n_checks++;
        if (itf.l_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_nonclosing_rdy: got %b required 1", itf.l_rdy);
        end
        send_beat(mk8(30, 0, -3, -100, 7, 7, 7, 7), 1'b0);
        itf.l_valid = 1'b1; itf.d_in = mk8(40, 0, -4, -100, 7, 7, 7, 7);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (itf.l_rdy === 1'b0) low_cnt++;
            check_out($sformatf("bp_hold_c%0d", c), exp_w[0], 1'b0);
        end
        n_checks++;
        if (low_cnt != 10) begin
            n_fail++;
            $display("FAIL bp_closing_stall: l_rdy low %0d cycles required 10", low_cnt);
        end
        itf.r_rdy = 1'b1;
        send_beat(mk8(40, 0, -4, -100, 7, 7, 7, 7), 1'b0);
        send_beat(mk8(50, 0, -5, -100, 7, 7, 7, 7), 1'b0);
        send_beat(mk8(60, 0, -6, -100, 7, 7, 7, 7), 1'b0);
        idle(3);
        n_checks++;
        if (q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d required 3", q.size());
        end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            n_checks++;
            if (q[i].d !== exp_w[i]) begin
                n_fail++;
                $display("FAIL bp_out%0d: got %h required %h", i, q[i].d, exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        mode = 1'b1; pool_w = 2'd2; itf.r_rdy = 1'b1;
        send_beat(mk8(1000, 999, 500, 500, 0, 0, 0, 0), 1'b0);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (itf.r_valid !== 1'b0 || itf.T_out !== '0 || itf.T_last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b d=%h l=%b required all zero", itf.r_valid, itf.T_out, itf.T_last_out);
        end
        idle(2);
        rstn = 1'b1;
        q.delete();
        idle(1);
        send_beat(mk8(1, 0, -7, -10, 0, 0, 0, 0), 1'b0);
        send_beat(mk8(2, 0, -6, -10, 0, 0, 0, 0), 1'b0);
        n_checks++;
        if (itf.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale: got r_valid=%b after 2 beats required 0", itf.r_valid);
        end
        send_beat(mk8(3, 0, -9, -10, 0, 0, 0, 0), 1'b0);
        check_out("midreset_window", mk8r(3, -6, 0, 0, 0, 0, 0, 0), 1'b0);
        idle(2);
        n_checks++;
        if (q.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d required 1", q.size());
        end
    endtask

    task automatic test_boundary();
        mode = 1'b1; pool_w = 2'd0; itf.r_rdy = 1'b1;
        send_beat(mk8(-32768, -32768, 5, 5, -32768, -32767, 32767, -32768), 1'b0);
        check_out("extremes", mk8r(-32768, 5, -32767, 32767, 0, 0, 0, 0), 1'b0);
        send_beat(mk8(-5, -3, -3, -5, -5, -3, -3, -5), 1'b0);
        check_out("relu_negative", mk8r(-3, -3, -3, -3, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic test_mode_sampling();
        mode = 1'b1; pool_w = 2'd1; itf.r_rdy = 1'b1;
        send_beat(mk8(1, 2, 0, 0, 0, 0, 0, 0), 1'b0);
        mode = 1'b0; pool_w = 2'd0;
        n_checks++;
        if (itf.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_first: got r_valid=%b required 0", itf.r_valid);
        end
        send_beat(mk8(9, 4, 0, 0, 0, 0, 0, 0), 1'b0);
        check_out("sample_close", mk8r(9, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        send_beat(mk8(-1, -2, -3, -4, 5, 6, 7, 8), 1'b1);
        check_out("sample_bypass", mk8r(-1, -2, -3, -4, 5, 6, 7, 8), 1'b1);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_pool_basic();
        test_partial_flush();
        test_back_to_back();
        test_reset_mid_window();
        test_boundary();
        test_mode_sampling();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
